fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST words (or until its packet ends) into a shared synchronous FIFO.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned GID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_data,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   burst_cnt;
    logic [GID_W-1:0]   rr_ptr;
    logic [GID_W-1:0]   scan_idx;
    logic [GID_W-1:0]   sel_id;
    logic               any_valid;
    logic               gnt_valid;
    logic               gnt_last;
    logic [WIDTH-1:0]   gnt_data;
    logic               transfer;
    logic               burst_end;
    logic [GID_W-1:0]   rr_next;

    // Pick the first valid requester at or after rr_ptr; reverse scan so the
    // closest one to rr_ptr is assigned last and wins.
    always_comb begin
        sel_id    = rr_ptr;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            scan_idx = GID_W'((int'(rr_ptr) + i) % int'(N_REQ));
            if (req_valid[scan_idx]) begin
                any_valid = 1'b1;
                sel_id    = scan_idx;
            end
        end
    end

    // Mux out the granted requester's handshake signals and data.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_id == GID_W'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer  = (state == BURST) && gnt_valid && !fifo_full;
    assign burst_end = transfer &&
                       (gnt_last || (CNT_W'(burst_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST)));
    assign rr_next   = (grant_id == GID_W'(N_REQ - 1)) ? '0 : GID_W'(grant_id + GID_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: enter BURST on any request, leave on burst end.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = BURST;
            BURST:   if (burst_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: only the granted requester sees ready, and only when the FIFO has room.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        busy       = 1'b0;
        if (state == BURST) begin
            busy       = 1'b1;
            fifo_wr_en = transfer;
            fifo_data  = gnt_data;
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (grant_id == GID_W'(i)) req_ready[i] = !fifo_full;
            end
        end
    end

    // Grant, burst counter and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id  <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                grant_id  <= sel_id;
                burst_cnt <= '0;
            end else if (transfer) begin
                burst_cnt <= CNT_W'(burst_cnt + CNT_W'(1));
            end
            if (burst_end) rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queue models drive the DUT,
// expected FIFO writes go into a scoreboard that a negedge monitor drains.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_data;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] rq [4][$];      // {last, data} per requester
    logic [17:0] sb [$];         // {grant_id, data} expected FIFO writes
    logic [3:0]  en;
    logic [3:0]  fired;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fifo_wr_en && fifo_full) begin
                n_tests++; n_fail++;
                $display("FAIL wr_while_full: fifo_wr_en=1 with fifo_full=1 at %0t", $time);
            end
            if (fifo_wr_en) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got gid %0d data %h, expected none", grant_id, fifo_data);
                end else begin
                    logic [17:0] e;
                    e = sb.pop_front();
                    if ({grant_id, fifo_data} !== e) begin
                        n_fail++;
                        $display("FAIL write: got gid %0d data %h expected gid %0d data %h",
                                 grant_id, fifo_data, e[17:16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() != 0) begin
                req_valid[i]         = en[i];
                req_data[i*16 +: 16] = rq[i][0][15:0];
                req_last[i]          = rq[i][0][16];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*16 +: 16] = 16'h0;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input logic [15:0] d, input logic last);
        rq[i].push_back({last, d});
    endtask

    task automatic expect_wr(input logic [1:0] g, input logic [15:0] d);
        sb.push_back({g, d});
    endtask

    // One clock: capture handshakes mid-cycle, retire accepted words after the edge.
    task automatic tick();
        @(negedge clk);
        fired = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (fired[i]) void'(rq[i].pop_front());
        drive();
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || rq[0].size() != 0 || rq[1].size() != 0 ||
                rq[2].size() != 0 || rq[3].size() != 0) && k < budget) begin
            tick();
            k++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        en        = 4'h0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        sb.delete();
        drive();
        @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_data", 32'(fifo_data), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0; en = '0; fired = '0;

        // Reset release with requesters 1 and 2 valid: 1 wins first.
        do_reset();
        load(1, 16'h1001, 1'b1); load(2, 16'h2001, 1'b1);
        expect_wr(2'd1, 16'h1001); expect_wr(2'd2, 16'h2001);
        en = 4'hF; drive(); #1;
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        check("t36_gid", 32'(grant_id), 32'd1);
        check("t36_busy", 32'(busy), 32'd1);
        check("t36_ready", 32'(req_ready), 32'b0010);
        drain("t36", 40);

        // All four valid with last on every word: round robin 0,1,2,3,0.
        do_reset();
        load(0, 16'h0001, 1'b1); load(0, 16'h0002, 1'b1);
        load(1, 16'h1001, 1'b1); load(2, 16'h2001, 1'b1); load(3, 16'h3001, 1'b1);
        expect_wr(2'd0, 16'h0001); expect_wr(2'd1, 16'h1001); expect_wr(2'd2, 16'h2001);
        expect_wr(2'd3, 16'h3001); expect_wr(2'd0, 16'h0002);
        en = 4'hF; drive(); #1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t37_busy", 32'(busy), 32'(k % 2));
            if (k % 2 == 1) check("t37_gid", 32'(grant_id), 32'(order[(k-1)/2]));
        end
        drain("t37", 10);

        // Six words without last from requester 2: burst capped at 4, then regrant.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            load(2, 16'(16'h2000 + k), 1'b0);
            expect_wr(2'd2, 16'(16'h2000 + k));
        end
        en = 4'hF; drive(); #1;
        for (int k = 1; k <= 4; k++) tick();
        check("t38_busy_c4", 32'(busy), 32'd1);
        tick();
        check("t38_idle", 32'(busy), 32'd0);
        tick();
        check("t38_regrant_busy", 32'(busy), 32'd1);
        check("t38_regrant_gid", 32'(grant_id), 32'd2);
        drain("t38", 20);
        check("t38_hold_burst", 32'(busy), 32'd1);

        // FIFO full for three cycles after word 2.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            load(0, 16'(16'h0000 + k), (k == 4) ? 1'b1 : 1'b0);
            expect_wr(2'd0, 16'(16'h0000 + k));
        end
        en = 4'hF; drive(); #1;
        tick(); tick(); tick();
        fifo_full = 1'b1; drive(); #1;
        for (int k = 0; k < 3; k++) begin
            check("t39_wr_en", 32'(fifo_wr_en), 32'd0);
            check("t39_ready", 32'(req_ready), 32'd0);
            check("t39_busy", 32'(busy), 32'd1);
            tick();
        end
        fifo_full = 1'b0; drive(); #1;
        drain("t39", 20);
        check("t39_end_idle", 32'(busy), 32'd0);

        // Reset mid-burst with grant 3 after two words.
        do_reset();
        for (int k = 1; k <= 4; k++) load(3, 16'(16'h3000 + k), 1'b0);
        expect_wr(2'd3, 16'h3001); expect_wr(2'd3, 16'h3002);
        en = 4'hF; drive(); #1;
        tick(); tick(); tick();
        check("t40_pre_gid", 32'(grant_id), 32'd3);
        check("t40_pre_sb", 32'(sb.size()), 32'd0);
        rst_n = 1'b0; #1;
        check("t40_busy", 32'(busy), 32'd0);
        check("t40_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t40_gid", 32'(grant_id), 32'd0);
        do_reset();
        load(1, 16'h1001, 1'b1); load(3, 16'h3001, 1'b1);
        expect_wr(2'd1, 16'h1001); expect_wr(2'd3, 16'h3001);
        en = 4'hF; drive(); #1;
        tick();
        check("t40_regrant_gid", 32'(grant_id), 32'd1);
        drain("t40", 20);

        // Granted requester 1 pauses two cycles while requester 0 keeps asking.
        do_reset();
        load(1, 16'h1001, 1'b0); load(1, 16'h1002, 1'b0); load(1, 16'h1003, 1'b1);
        load(0, 16'h0001, 1'b1); load(0, 16'h0002, 1'b1);
        expect_wr(2'd1, 16'h1001); expect_wr(2'd1, 16'h1002); expect_wr(2'd1, 16'h1003);
        expect_wr(2'd0, 16'h0001); expect_wr(2'd0, 16'h0002);
        en = 4'b0010; drive(); #1;
        tick();
        en = 4'b0011; drive(); #1;
        tick();
        en = 4'b0001; drive(); #1;
        for (int k = 0; k < 2; k++) begin
            check("t41_wr_en", 32'(fifo_wr_en), 32'd0);
            check("t41_gid", 32'(grant_id), 32'd1);
            check("t41_busy", 32'(busy), 32'd1);
            tick();
        end
        en = 4'b0011; drive(); #1;
        drain("t41", 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
